// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    localparam int unsigned CNT_WIDTH      = 16;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_e;

    function automatic logic is_load_state(input state_e s);
        return s inside {HDR_HI, HDR_LO, DATA, CSUM};
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot loader: parses a counted, XOR-checksummed byte frame into big-endian words,
// writes them to instruction memory from address 0 and releases the CPU on success.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned MAX_WORDS  = 2 ** ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        imem_wr_en,
    output logic [31:0] imem_wr_addr,
    output logic [31:0] imem_wr_data,
    output logic        cpu_rst_hold,
    output logic        done,
    output logic        error
);

    localparam int unsigned IDX_W = ADDR_WIDTH + 1;

    state_e                 state_q, state_d;
    logic                   in_ready_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic [31:0]            word_q;
    logic [1:0]             bidx_q;
    logic [7:0]             csum_q;
    logic [IDX_W-1:0]       widx_q;
    logic                   wr_en_q;
    logic [31:0]            wr_data_q;

    logic                   accept;
    logic                   restart;
    logic                   last_byte;
    logic                   last_word;
    logic [CNT_WIDTH-1:0]   hdr_n;

    assign accept    = in_valid && in_ready_q;
    assign restart   = start && (state_q inside {IDLE, DONE, ERROR});
    assign last_byte = (bidx_q == 2'(BYTES_PER_WORD - 1));
    assign last_word = ((32'(widx_q) + 32'd1) == 32'(count_q));
    assign hdr_n     = {count_q[15:8], in_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= is_load_state(state_d);
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE, ERROR: if (start) state_d = HDR_HI;
            HDR_HI:            if (accept) state_d = HDR_LO;
            HDR_LO: begin
                if (accept) begin
                    if (32'(hdr_n) > 32'(MAX_WORDS)) state_d = ERROR;
                    else if (hdr_n == '0)            state_d = CSUM;
                    else                             state_d = DATA;
                end
            end
            DATA:              if (accept && last_byte && last_word) state_d = CSUM;
            CSUM:              if (accept) state_d = (in_data == csum_q) ? DONE : ERROR;
            default:           state_d = IDLE;
        endcase
    end

    // Word index advances at the end of the write cycle, so the write sees the
    // current word's address and DONE is left holding 4*N.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            word_q    <= '0;
            bidx_q    <= '0;
            csum_q    <= '0;
            widx_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (wr_en_q) widx_q <= widx_q + 1'b1;
            if (restart) begin
                word_q <= '0;
                bidx_q <= '0;
                csum_q <= '0;
                widx_q <= '0;
            end
            if (accept && state_q == HDR_HI) count_q[15:8] <= in_data;
            if (accept && state_q == HDR_LO) count_q[7:0]  <= in_data;
            if (accept && state_q == DATA) begin
                word_q <= {word_q[23:0], in_data};
                csum_q <= csum_q ^ in_data;
                bidx_q <= bidx_q + 2'd1;
                if (last_byte) begin
                    wr_en_q   <= 1'b1;
                    wr_data_q <= {word_q[23:0], in_data};
                end
            end
        end
    end

    always_comb begin
        in_ready     = in_ready_q;
        imem_wr_en   = wr_en_q;
        imem_wr_data = wr_data_q;
        imem_wr_addr = {{(32 - IDX_W - 2){1'b0}}, widx_q, 2'b00};
        done         = (state_q == DONE);
        error        = (state_q == ERROR);
        cpu_rst_hold = (state_q != DONE);
    end

endmodule
